// File: rtl/linebuffer_2x2_stream.sv
// Streaming 2x2 window generator over a square raster frame held in a single line buffer.
// Define LINEBUFFER_2X2_STRIDE1_EN for run-time stride-1/stride-2 selection; otherwise the block is stride-2 only.
module linebuffer_2x2_stream #(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int W1     = 416,
  parameter int W2     = 208,
  parameter int W3     = 104,
  parameter int W4     = 52,
  parameter int W5     = 26,
  parameter int W6     = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               sel,
  input  logic                     stride2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W*CH-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*DATA_W*CH-1:0]   out_win,
  output logic                     frame_done
);

  localparam int PIX_W = DATA_W * CH;
  localparam int M_A   = (W1 > W2) ? W1 : W2;
  localparam int M_B   = (W3 > W4) ? W3 : W4;
  localparam int M_C   = (W5 > W6) ? W5 : W6;
  localparam int M_AB  = (M_A > M_B) ? M_A : M_B;
  localparam int MAXW  = (M_AB > M_C) ? M_AB : M_C;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int AW    = (MAXW > 1) ? $clog2(MAXW) : 1;

  function automatic logic [CW-1:0] w_decode(input logic [2:0] s);
    case (s)
      3'd0:    w_decode = CW'(W1);
      3'd1:    w_decode = CW'(W2);
      3'd2:    w_decode = CW'(W3);
      3'd3:    w_decode = CW'(W4);
      3'd4:    w_decode = CW'(W5);
      default: w_decode = CW'(W6);
    endcase
  endfunction

  logic [PIX_W-1:0]   line_mem [MAXW];
  logic [CW-1:0]      col_q, col_d, row_q, row_d, w_q, w_d;
  logic [PIX_W-1:0]   top_prev_q, top_prev_d, cur_prev_q, cur_prev_d;
  logic               out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic [4*PIX_W-1:0] out_win_q, out_win_d;
  logic               accept_s, first_s, col_last_s, row_last_s, emit_s;
  logic [CW-1:0]      w_cur_s;
  logic [PIX_W-1:0]   top_s;

  assign in_ready   = out_ready || !out_valid_q;
  assign accept_s   = in_valid && in_ready;
  assign first_s    = (row_q == '0) && (col_q == '0);
  // Frame geometry comes from sel only on the first pixel; afterwards the latched width rules.
  assign w_cur_s    = first_s ? w_decode(sel) : w_q;
  assign col_last_s = (col_q == (w_cur_s - 1'b1));
  assign row_last_s = (row_q == (w_cur_s - 1'b1));
  assign top_s      = line_mem[col_q[AW-1:0]];

`ifdef LINEBUFFER_2X2_STRIDE1_EN
  logic s2_q, s2_d;
  assign emit_s = accept_s && (row_q != '0) && (col_q != '0) &&
                  (!s2_q || (row_q[0] && col_q[0]));
`else
  logic unused_stride2;
  assign unused_stride2 = stride2;
  assign emit_s = accept_s && row_q[0] && col_q[0];
`endif

  // Next-state for counters, window history and the output register.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    w_d          = w_q;
    top_prev_d   = top_prev_q;
    cur_prev_d   = cur_prev_q;
    out_valid_d  = out_valid_q;
    out_win_d    = out_win_q;
    frame_done_d = 1'b0;
`ifdef LINEBUFFER_2X2_STRIDE1_EN
    s2_d         = s2_q;
    if (accept_s && first_s) begin
      s2_d = stride2;
    end else begin
      s2_d = s2_q;
    end
`endif
    if (accept_s) begin
      w_d          = w_cur_s;
      top_prev_d   = top_s;
      cur_prev_d   = in_data;
      frame_done_d = col_last_s && row_last_s;
      if (col_last_s) begin
        col_d = '0;
        row_d = row_last_s ? '0 : (row_q + 1'b1);
      end else begin
        col_d = col_q + 1'b1;
      end
    end else begin
      frame_done_d = 1'b0;
    end
    if (emit_s) begin
      out_valid_d = 1'b1;
      out_win_d   = {in_data, cur_prev_q, top_s, top_prev_q};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= CW'(W6);
      top_prev_q   <= '0;
      cur_prev_q   <= '0;
      out_valid_q  <= 1'b0;
      out_win_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef LINEBUFFER_2X2_STRIDE1_EN
      s2_q         <= 1'b1;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      w_q          <= w_d;
      top_prev_q   <= top_prev_d;
      cur_prev_q   <= cur_prev_d;
      out_valid_q  <= out_valid_d;
      out_win_q    <= out_win_d;
      frame_done_q <= frame_done_d;
`ifdef LINEBUFFER_2X2_STRIDE1_EN
      s2_q         <= s2_d;
`endif
    end
  end

  // Line buffer: slot col holds pixel (r-1,col) until overwritten by (r,col).
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line_mem[col_q[AW-1:0]] <= in_data;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_win    = out_win_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_linebuffer_2x2_stream.sv
// Directed bench for linebuffer_2x2_stream: CH=1 and CH=4 instances driven in lockstep.
module tb_linebuffer_2x2_stream;

  logic         clk = 1'b0;
  logic         rst, stride2, in_valid, out_ready;
  logic [2:0]   sel;
  logic [7:0]   in_data;
  logic         in_ready, out_valid, frame_done;
  logic [31:0]  out_win;
  logic [31:0]  in_data4;
  logic         in_ready4, out_valid4, frame_done4;
  logic [127:0] out_win4;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int cyc    = 0;
  int fd_cnt = 0, fd4_cnt = 0, stab_err = 0, stall_cnt = 0;
  logic        acc_q = 1'b0, stall_q = 1'b0;
  logic [31:0] held_q = 32'h0;
  logic [31:0]  q1[$], exp1[$];
  logic [127:0] q4[$], exp4[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] pix4(input logic [7:0] p);
    return {p ^ 8'hC0, p ^ 8'h80, p ^ 8'h40, p};
  endfunction

  function automatic logic [7:0] pv(input int r, input int c);
    return 8'((r * 16 + c) & 255);
  endfunction

  assign in_data4 = pix4(in_data);

  linebuffer_2x2_stream #(.DATA_W(8), .CH(1)) dut (
    .clk(clk), .rst(rst), .sel(sel), .stride2(stride2),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
    .frame_done(frame_done));

  linebuffer_2x2_stream #(.DATA_W(8), .CH(4)) dut4 (
    .clk(clk), .rst(rst), .sel(sel), .stride2(stride2),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_win(out_win4),
    .frame_done(frame_done4));

  // Output monitor: collects windows, counts frame_done pulses, watches stall stability.
  always @(posedge clk) begin
    acc_q <= in_valid && in_ready && in_ready4;
    if (!rst && out_valid && out_ready) q1.push_back(out_win);
    if (!rst && out_valid4 && out_ready) q4.push_back(out_win4);
    if (!rst && frame_done) fd_cnt <= fd_cnt + 1;
    if (!rst && frame_done4) fd4_cnt <= fd4_cnt + 1;
    if (!rst && stall_q && (out_valid !== 1'b1 || out_win !== held_q)) stab_err <= stab_err + 1;
    if (!rst && out_valid && !out_ready) stall_cnt <= stall_cnt + 1;
    stall_q <= !rst && out_valid && !out_ready;
    held_q  <= out_win;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept();
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!acc_q && t < 200);
    check("accept_timeout", acc_q, 1'b1);
    if (!acc_q) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  task automatic send_frame(input int w, input logic [2:0] sel_a, input logic [2:0] sel_b,
                            input int sw_idx, input logic s2, input int limit,
                            input bit gaps, input bit lat_chk);
    int idx = 0;
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        if (idx < limit) begin
          if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          sel     = (idx >= sw_idx) ? sel_b : sel_a;
          stride2 = s2;
          in_data = pv(r, c);
          in_valid = 1'b1;
          wait_accept();
          if (lat_chk && r == 1 && c == 1) begin
            check("latency_valid", out_valid, 1'b1);
            check("latency_win", out_win, 32'h11100100);
          end
          if (r == w - 1 && c == w - 1) check("frame_done_pulse", frame_done, 1'b1);
          idx++;
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("frame_done_clear", frame_done, 1'b0);
  endtask

  task automatic drain();
    int t = 0;
    while ((out_valid || out_valid4) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input int w, input bit s2);
    bit es2;
    logic [7:0] p00, p01, p10, p11;
`ifdef LINEBUFFER_2X2_STRIDE1_EN
    es2 = s2;
`else
    es2 = 1'b1;
    if (s2) es2 = 1'b1;
`endif
    exp1.delete();
    exp4.delete();
    for (int r = 1; r < w; r++) begin
      for (int c = 1; c < w; c++) begin
        if (!es2 || ((r % 2) == 1 && (c % 2) == 1)) begin
          p00 = pv(r - 1, c - 1); p01 = pv(r - 1, c);
          p10 = pv(r, c - 1);     p11 = pv(r, c);
          exp1.push_back({p11, p10, p01, p00});
          exp4.push_back({pix4(p11), pix4(p10), pix4(p01), pix4(p00)});
        end
      end
    end
  endtask

  task automatic cmp_windows(input string tag);
    int n;
    check({tag, "_count"}, q1.size(), exp1.size());
    check({tag, "_count4"}, q4.size(), exp4.size());
    n = (q1.size() < exp1.size()) ? q1.size() : exp1.size();
    for (int i = 0; i < n; i++) check({tag, "_win"}, q1[i], exp1[i]);
    n = (q4.size() < exp4.size()) ? q4.size() : exp4.size();
    for (int i = 0; i < n; i++) check({tag, "_win4"}, q4[i], exp4[i]);
  endtask

  task automatic clear_q();
    q1.delete();
    q4.delete();
  endtask

  initial begin
    int fd0, fd40;
    logic [31:0] w_last;
    logic [127:0] w4_first;

    // Reset state, with the sink stalled so in_ready depends only on out_valid.
    mode = 2; rst = 1'b1; in_valid = 1'b0; sel = 3'd5; stride2 = 1'b1; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_win", out_win, 32'h0);
    check("rst_out_win4", out_win4, 128'h0);
    check("rst_frame_done", frame_done, 1'b0);
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);
    mode = 0;
    @(posedge clk); #1;

    // Frame A: W=13 stride-2, no backpressure.
    clear_q(); fd0 = fd_cnt; fd40 = fd4_cnt;
    send_frame(13, 3'd5, 3'd5, 100000, 1'b1, 100000, 1'b0, 1'b1);
    drain();
    build_exp(13, 1'b1);
    cmp_windows("frameA");
    check("frameA_n36", q1.size(), 36);
    check("frameA_first", (q1.size() > 0) ? q1[0] : 32'hDEADBEEF, 32'h11100100);
    w_last = (q1.size() > 0) ? q1[q1.size() - 1] : 32'hDEADBEEF;
    check("frameA_last", w_last, 32'hBBBAABAA);
    w4_first = (q4.size() > 0) ? q4[0] : 128'h0;
    check("frameA_lane_rc", w4_first[127:96], 32'hD1915111);
    check("frameA_lane_r1c1", w4_first[31:0], 32'hC0804000);
    check("frameA_fd", fd_cnt - fd0, 1);
    check("frameA_fd4", fd4_cnt - fd40, 1);

    // Frame B: stride2=0 (only honoured when stride-1 support is built in).
    clear_q();
    send_frame(13, 3'd5, 3'd5, 100000, 1'b0, 100000, 1'b0, 1'b0);
    drain();
    build_exp(13, 1'b0);
    cmp_windows("frameB");
`ifdef LINEBUFFER_2X2_STRIDE1_EN
    check("frameB_n144", q1.size(), 144);
    check("frameB_first", (q1.size() > 0) ? q1[0] : 32'hDEADBEEF, 32'h11100100);
    check("frameB_second", (q1.size() > 1) ? q1[1] : 32'hDEADBEEF, 32'h12110201);
`else
    check("frameB_n36", q1.size(), 36);
`endif

    // Frame C: sink ready one cycle in three, random input gaps.
    clear_q(); fd0 = fd_cnt;
    mode = 1;
    send_frame(13, 3'd5, 3'd5, 100000, 1'b1, 100000, 1'b1, 1'b0);
    drain();
    mode = 0;
    build_exp(13, 1'b1);
    cmp_windows("frameC");
    check("frameC_fd", fd_cnt - fd0, 1);
    check("frameC_stall_stable", stab_err, 0);
    check("frameC_stalls_seen", stall_cnt > 0, 1'b1);

    // Reset after 50 accepted pixels, then a clean frame.
    send_frame(13, 3'd5, 3'd5, 100000, 1'b1, 50, 1'b0, 1'b0);
    drain();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_q(); fd0 = fd_cnt;
    check("midrst_out_valid", out_valid, 1'b0);
    send_frame(13, 3'd5, 3'd5, 100000, 1'b1, 100000, 1'b0, 1'b1);
    drain();
    build_exp(13, 1'b1);
    cmp_windows("midrst");
    check("midrst_fd", fd_cnt - fd0, 1);

    // sel changes 5->4 mid-frame (ignored), then a W=26 frame.
    clear_q(); fd0 = fd_cnt;
    send_frame(13, 3'd5, 3'd4, 42, 1'b1, 100000, 1'b0, 1'b0);
    drain();
    build_exp(13, 1'b1);
    cmp_windows("selchg13");
    check("selchg13_fd", fd_cnt - fd0, 1);
    clear_q(); fd0 = fd_cnt;
    mode = 1;
    send_frame(26, 3'd4, 3'd4, 100000, 1'b1, 100000, 1'b1, 1'b0);
    drain();
    mode = 0;
    build_exp(26, 1'b1);
    cmp_windows("w26");
    check("w26_n169", q1.size(), 169);
    check("w26_fd", fd_cnt - fd0, 1);

    // sel=7 aliases to W6 (13).
    clear_q(); fd0 = fd_cnt;
    send_frame(13, 3'd7, 3'd7, 100000, 1'b1, 100000, 1'b0, 1'b1);
    drain();
    build_exp(13, 1'b1);
    cmp_windows("sel7");
    check("sel7_fd", fd_cnt - fd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/linebuffer_2x2_stream.md
LINEBUFFER_2X2_STREAM -- requirements
Module: linebuffer_2x2_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per channel sample.
REQ-002 SHALL have parameter CH, default 1, meaning channels packed per pixel; PIX_W = DATA_W*CH.
REQ-003 SHALL have parameters W1..W6, defaults 416,208,104,52,26,13, meaning selectable square frame widths (pixels per row = rows per frame).
REQ-004 SHALL have ports: clk, input, 1, clock. One clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports: sel, input, 3, frame-width select; 0..5 -> W1..W6; 6 and 7 -> W6.
REQ-007 SHALL have ports: stride2, input, 1, 1 = stride-2 window emission, 0 = stride-1.
REQ-008 SHALL have ports: in_valid, input, 1; in_ready, output, 1; in_data, input, PIX_W; raster-order pixel stream.
REQ-009 SHALL have ports: out_valid, output, 1; out_ready, input, 1; out_win, output, 4*PIX_W.
REQ-010 SHALL have ports: frame_done, output, 1, one-cycle pulse.

Function
REQ-011 Accept SHALL occur when in_valid && in_ready; line storage, window registers and counters advance only on accept.
REQ-012 in_ready SHALL equal out_ready || !out_valid.
REQ-013 Column counter col SHALL run 0..W-1; on wrap, row counter SHALL increment; row wraps 0 after W-1.
REQ-014 sel and stride2 SHALL be latched on accept of pixel (row 0, col 0); later changes within the frame SHALL be ignored.
REQ-015 Row delay SHALL be exactly W accepted pixels for the latched W.
REQ-016 out_win packing SHALL be [PIX_W-1:0]=(r-1,c-1), [2PIX_W-1:PIX_W]=(r-1,c), [3PIX_W-1:2PIX_W]=(r,c-1), [4PIX_W-1:3PIX_W]=(r,c), for accepted pixel (r,c).
REQ-017 A window SHALL be emitted for accepted pixel (r,c) iff r>=1, c>=1 and (stride2=0 or r,c both odd).
REQ-018 Emission latency SHALL be 1 cycle: out_valid and out_win registered on the cycle after accept.
REQ-019 out_valid SHALL hold with out_win stable until out_valid && out_ready.
REQ-020 Columns c=0 SHALL never pair with previous-row pixels (no wrap-around windows).
REQ-021 frame_done SHALL pulse for one cycle, 1 cycle after accept of pixel (W-1,W-1), independent of out_ready.
REQ-022 Simultaneous output handshake and new emission SHALL load the new window without bubble.
REQ-023 Odd W with stride2 SHALL drop the last row and column (floor semantics).

Reset
REQ-024 On rst: col=0, row=0, out_valid=0, out_win=0, frame_done=0; in_ready=1 the cycle after rst deasserts.
REQ-025 Line storage SHALL not require reset; stale contents SHALL never appear in emitted windows.
REQ-026 Reset mid-frame SHALL discard the partial frame; next accepted pixel is (0,0).

Configuration
REQ-027 Macro LINEBUFFER_2X2_STRIDE1_EN: defined -> stride2 behaves as REQ-017.
REQ-028 Without LINEBUFFER_2X2_STRIDE1_EN: stride2 port ignored, block always stride-2; stride-1 logic absent.

Verification
REQ-029 CH=1, sel=5 (W=13), stride2=1, pixel=row*16+col, no backpressure -> 36 windows; first out_win=0x11100100; last=0xBBBAABAA; one frame_done.
REQ-030 Same frame, stride2=0 (macro defined) -> 144 windows; first 0x11100100, second 0x12110201; none with c=0.
REQ-031 out_ready toggled 1-of-3 cycles, random in_valid -> identical 36-window sequence, no loss/duplication, out_win stable while stalled.
REQ-032 rst asserted after 50 accepted pixels, then full 13x13 frame -> outputs match REQ-029 exactly; no window from aborted frame.
REQ-033 sel changed 5->4 at pixel (3,3), then 26x26 frame with sel=4 -> first frame completes as W=13; second yields 169 stride-2 windows, one frame_done each.
REQ-034 CH=4, DATA_W=8, W=13 -> per-channel lanes match REQ-029 expectations in lane order.
